// File: rtl/chunk_row_looper_if.sv
// Descriptor and row handshake bundle for chunk_row_looper.
// The design side uses the slave modport; the descriptor source/row sink uses master.
interface chunk_row_looper_if #(
  parameter int GBW  = 32,
  parameter int DIM  = 4,
  parameter int V_BW = 3
);
  logic                     i_mofs_rdy;
  logic                     o_mofs_ack;
  logic [GBW*(DIM-1)-1:0]   i_mofs;
  logic [GBW*(DIM-1)-1:0]   i_mstride;
  logic [GBW*(DIM-1)-1:0]   i_mlast;
  logic [GBW*(DIM-1)-1:0]   i_mbound;
  logic [2*(DIM-1)-1:0]     i_mmode;
  logic [V_BW*DIM-1:0]      i_mpad;
  logic [GBW-1:0]           i_maddr;
  logic                     o_row_rdy;
  logic                     i_row_ack;
  logic [GBW-1:0]           o_row_linear;
  logic [V_BW-1:0]          o_row_pad;
  logic                     o_row_islast;
  logic                     o_row_oob;

  modport master (
    output i_mofs_rdy, i_mofs, i_mstride, i_mlast, i_mbound, i_mmode, i_mpad, i_maddr, i_row_ack,
    input  o_mofs_ack, o_row_rdy, o_row_linear, o_row_pad, o_row_islast, o_row_oob
  );

  modport slave (
    input  i_mofs_rdy, i_mofs, i_mstride, i_mlast, i_mbound, i_mmode, i_mpad, i_maddr, i_row_ack,
    output o_mofs_ack, o_row_rdy, o_row_linear, o_row_pad, o_row_islast, o_row_oob
  );
endinterface

// File: rtl/chunk_row_looper.sv
// Row-start generator: latches one chunk descriptor, walks the outer-row counter and
// emits one registered row (address, pad, last, oob) per cycle with boundary handling.
module chunk_row_looper #(
  parameter int GBW  = 32,
  parameter int DIM  = 4,
  parameter int V_BW = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  chunk_row_looper_if.slave bus
);
  localparam int ND = DIM - 1;
  localparam int IW = $clog2(DIM);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic signed [GBW-1:0]  r_mofs    [ND];
  logic signed [GBW-1:0]  r_mstride [ND];
  logic signed [GBW-1:0]  r_mlast   [ND];
  logic signed [GBW-1:0]  r_mbound  [ND];
  logic [1:0]             r_mmode   [ND];
  logic [V_BW-1:0]        r_mpad    [DIM];
  logic [GBW-1:0]         r_maddr;
  logic signed [GBW-1:0]  r_cur     [ND];

  logic                   r_row_rdy;
  logic [GBW-1:0]         r_row_linear;
  logic [V_BW-1:0]        r_row_pad;
  logic                   r_row_islast;
  logic                   r_row_oob;

  logic [ND-1:0]          w_at_last;
  logic                   w_all_last;
  logic [IW-1:0]          w_inc_dim;
  logic [IW-1:0]          w_pad_idx;
  logic signed [GBW-1:0]  w_cur_nxt [ND];
  logic [GBW:0]           w_map     [ND];
  logic [GBW-1:0]         w_sum;
  logic                   w_oob;
  logic [V_BW-1:0]        w_pad;
  logic                   w_load;

  // Map one dim position into range; returns {out_of_range_in_zero_mode, mapped}.
  function automatic logic [GBW:0] map_dim(
    input logic signed [GBW-1:0] u,
    input logic signed [GBW-1:0] bound,
    input logic signed [GBW-1:0] stride,
    input logic [1:0]            mode
  );
    logic signed [GBW-1:0] m;
    logic                  below;
    logic                  above;
    logic                  oob;
    below = u[GBW-1];
    above = (u > bound);
    oob   = 1'b0;
    if (below) begin
      m = '0;
    end else if (above) begin
      m = bound;
    end else begin
      m = u;
    end
    case (mode)
      2'd1: begin
        if (below) begin
          m = u + bound + stride;
        end else if (above) begin
          m = u - bound - stride;
        end else begin
          m = u;
        end
      end
      2'd2:    oob = below | above;
      default: oob = 1'b0;
    endcase
    return {oob, m};
  endfunction

  // Counter advance, row address, pad selection and oob for the current position.
  always_comb begin
    w_all_last = 1'b1;
    w_inc_dim  = '0;
    w_sum      = r_maddr;
    w_oob      = 1'b0;
    for (int i = 0; i < ND; i++) begin
      w_at_last[i] = (r_cur[i] == r_mlast[i]);
      w_all_last   = w_all_last & w_at_last[i];
      // Ascending scan: the innermost unfinished dim wins.
      w_inc_dim    = w_at_last[i] ? w_inc_dim : i[IW-1:0];
      w_map[i]     = map_dim(r_cur[i] + r_mofs[i], r_mbound[i], r_mstride[i], r_mmode[i]);
      w_sum        = w_sum + w_map[i][GBW-1:0];
      w_oob        = w_oob | w_map[i][GBW];
    end
    for (int i = 0; i < ND; i++) begin
      if (w_all_last || (i < int'(w_inc_dim))) begin
        w_cur_nxt[i] = r_cur[i];
      end else if (i == int'(w_inc_dim)) begin
        w_cur_nxt[i] = r_cur[i] + r_mstride[i];
      end else begin
        w_cur_nxt[i] = '0;
      end
    end
    w_pad_idx = w_inc_dim + IW'(1'b1);
    if (w_all_last) begin
      w_pad = r_mpad[0];
    end else begin
      w_pad = r_mpad[w_pad_idx];
    end
  end

  assign w_load = (r_state == ST_RUN) && (!r_row_rdy || bus.i_row_ack);

  // Control FSM, descriptor latch, row counter and the output row register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_maddr      <= '0;
      r_row_rdy    <= 1'b0;
      r_row_linear <= '0;
      r_row_pad    <= '0;
      r_row_islast <= 1'b0;
      r_row_oob    <= 1'b0;
      for (int i = 0; i < ND; i++) begin
        r_mofs[i]    <= '0;
        r_mstride[i] <= '0;
        r_mlast[i]   <= '0;
        r_mbound[i]  <= '0;
        r_mmode[i]   <= 2'd0;
        r_cur[i]     <= '0;
      end
      for (int k = 0; k < DIM; k++) begin
        r_mpad[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_mofs_rdy) begin
            for (int i = 0; i < ND; i++) begin
              r_mofs[i]    <= bus.i_mofs[i*GBW +: GBW];
              r_mstride[i] <= bus.i_mstride[i*GBW +: GBW];
              r_mlast[i]   <= bus.i_mlast[i*GBW +: GBW];
              r_mbound[i]  <= bus.i_mbound[i*GBW +: GBW];
              r_mmode[i]   <= bus.i_mmode[i*2 +: 2];
              r_cur[i]     <= '0;
            end
            for (int k = 0; k < DIM; k++) begin
              r_mpad[k] <= bus.i_mpad[k*V_BW +: V_BW];
            end
            r_maddr <= bus.i_maddr;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_load) begin
            for (int i = 0; i < ND; i++) begin
              r_cur[i] <= w_cur_nxt[i];
            end
            r_state <= w_all_last ? ST_IDLE : ST_RUN;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A pending row survives into IDLE until the sink takes it.
      if (w_load) begin
        r_row_rdy    <= 1'b1;
        r_row_linear <= w_sum;
        r_row_pad    <= w_pad;
        r_row_islast <= w_all_last;
        r_row_oob    <= w_oob;
      end else if (bus.i_row_ack) begin
        r_row_rdy    <= 1'b0;
      end else begin
        r_row_rdy    <= r_row_rdy;
      end
    end
  end

  assign bus.o_mofs_ack   = (r_state == ST_IDLE);
  assign bus.o_row_rdy    = r_row_rdy;
  assign bus.o_row_linear = r_row_linear;
  assign bus.o_row_pad    = r_row_pad;
  assign bus.o_row_islast = r_row_islast;
  assign bus.o_row_oob    = r_row_oob;
endmodule

// File: tb/tb_chunk_row_looper.sv
// Scoreboard bench for chunk_row_looper: directed 2-dim walks with hand-computed rows,
// a decoupled negedge monitor checking values and cycle stamps.
module tb_chunk_row_looper;
  localparam int GBW  = 32;
  localparam int DIM  = 3;
  localparam int V_BW = 3;
  localparam int NR   = 9;

  localparam logic [63:0] STRIDE = {32'd1, 32'd4};
  localparam logic [63:0] LAST9  = {32'd2, 32'd8};
  localparam logic [63:0] BOUND  = {32'd3, 32'd8};
  localparam logic [63:0] OFS0   = 64'd0;
  localparam logic [63:0] OFSM4  = {32'd0, 32'hFFFF_FFFC};
  localparam logic [63:0] OFSP4  = {32'd0, 32'd4};
  localparam logic [8:0]  PADTAB = {3'd6, 3'd3, 3'd5};

  typedef struct {
    logic [GBW-1:0]  lin;
    logic [V_BW-1:0] pad;
    logic            last;
    logic            oob;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t q[$];
  int e_addr[NR];
  logic [NR-1:0] e_oob;
  int acc, acc_a, acc_b;

  chunk_row_looper_if #(.GBW(GBW), .DIM(DIM), .V_BW(V_BW)) bus ();

  chunk_row_looper #(.GBW(GBW), .DIM(DIM), .V_BW(V_BW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Monitor: compare every presented row against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && bus.o_row_rdy) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_row actual=%0d required=no_row", bus.o_row_linear);
      end else begin
        chk("row_linear", bus.o_row_linear, q[0].lin);
        chk("row_pad", bus.o_row_pad, q[0].pad);
        chk("row_islast", bus.o_row_islast, q[0].last);
        chk("row_oob", bus.o_row_oob, q[0].oob);
        if (bus.i_row_ack) begin
          if (q[0].cyc >= 0) chk("row_cycle", cyc, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send_desc(input logic [63:0] ofs, input logic [3:0] mode,
                           input logic [31:0] addr, input logic [63:0] last, output int a);
    bit got;
    got = 1'b0;
    a = -1;
    bus.i_mofs = ofs;
    bus.i_mstride = STRIDE;
    bus.i_mlast = last;
    bus.i_mbound = BOUND;
    bus.i_mmode = mode;
    bus.i_mpad = PADTAB;
    bus.i_maddr = addr;
    bus.i_mofs_rdy = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.o_mofs_ack) begin
        got = 1'b1;
        a = cyc + 1;
      end
    end
    if (got) begin
      @(posedge clk);
      #1 bus.i_mofs_rdy = 1'b0;
    end else begin
      bus.i_mofs_rdy = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL desc_accept_timeout actual=no_ack required=ack");
    end
  endtask

  // stall=1 applies the stamps of the 3-cycle mid-chunk backpressure pattern.
  task automatic push_rows(input int a, input int n, input bit stall);
    exp_t e;
    if (a >= 0) begin
      for (int i = 0; i < n; i++) begin
        e.lin  = e_addr[i];
        e.pad  = (i == n - 1) ? 3'd5 : ((i % 3 == 2) ? 3'd3 : 3'd6);
        e.last = (i == n - 1);
        e.oob  = e_oob[i];
        if (!stall || i < 2) e.cyc = a + 1 + i;
        else if (i == 2)     e.cyc = a + 6;
        else                 e.cyc = a + 4 + i;
        q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_chunk(input logic [63:0] ofs, input logic [3:0] mode);
    int a;
    send_desc(ofs, mode, 32'd1000, LAST9, a);
    push_rows(a, NR, 1'b0);
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row_rdy"}, bus.o_row_rdy, 64'd0);
    chk({tag, "_linear"}, bus.o_row_linear, 64'd0);
    chk({tag, "_pad"}, bus.o_row_pad, 64'd0);
    chk({tag, "_islast"}, bus.o_row_islast, 64'd0);
    chk({tag, "_oob"}, bus.o_row_oob, 64'd0);
    chk({tag, "_mofs_ack"}, bus.o_mofs_ack, 64'd1);
  endtask

  initial begin
    bus.i_mofs_rdy = 1'b0;
    bus.i_mofs = '0;
    bus.i_mstride = '0;
    bus.i_mlast = '0;
    bus.i_mbound = '0;
    bus.i_mmode = '0;
    bus.i_mpad = '0;
    bus.i_maddr = '0;
    bus.i_row_ack = 1'b1;
    e_oob = '0;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    e_addr = '{1000, 1001, 1002, 1004, 1005, 1006, 1008, 1009, 1010};
    run_chunk(OFS0, 4'b0000);

    e_addr = '{1000, 1001, 1002, 1000, 1001, 1002, 1004, 1005, 1006};
    run_chunk(OFSM4, 4'b0000);
    run_chunk(OFSM4, 4'b0011);

    e_addr = '{1008, 1009, 1010, 1000, 1001, 1002, 1004, 1005, 1006};
    run_chunk(OFSM4, 4'b0001);

    e_addr = '{1000, 1001, 1002, 1000, 1001, 1002, 1004, 1005, 1006};
    e_oob = 9'b000000111;
    run_chunk(OFSM4, 4'b0010);

    e_addr = '{1004, 1005, 1006, 1008, 1009, 1010, 1000, 1001, 1002};
    e_oob = 9'b000000000;
    run_chunk(OFSP4, 4'b0001);

    e_addr = '{1004, 1005, 1006, 1008, 1009, 1010, 1008, 1009, 1010};
    e_oob = 9'b111000000;
    run_chunk(OFSP4, 4'b0010);

    e_oob = 9'b000000000;
    e_addr[0] = 2000;
    send_desc(OFS0, 4'b0000, 32'd2000, 64'd0, acc);
    push_rows(acc, 1, 1'b0);
    drain();

    // Backpressure mid-chunk with the next descriptor already waiting.
    e_addr = '{1000, 1001, 1002, 1004, 1005, 1006, 1008, 1009, 1010};
    send_desc(OFS0, 4'b0000, 32'd1000, LAST9, acc_a);
    push_rows(acc_a, NR, 1'b1);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.i_row_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.i_row_ack = 1'b1;
      end
      begin
        send_desc(OFSM4, 4'b0001, 32'd1000, LAST9, acc_b);
      end
    join
    chk("b2b_accept_cycle", acc_b, acc_a + 13);
    e_addr = '{1008, 1009, 1010, 1000, 1001, 1002, 1004, 1005, 1006};
    push_rows(acc_b, NR, 1'b0);
    drain();

    // Reset dropped mid-walk after four rows.
    e_addr = '{1000, 1001, 1002, 1004, 1005, 1006, 1008, 1009, 1010};
    send_desc(OFS0, 4'b0000, 32'd1000, LAST9, acc);
    push_rows(acc, NR, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    chk("rst_rows_pending", q.size(), 64'd5);
    q.delete();
    #1 check_reset_outputs("midrun_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_mofs_ack", bus.o_mofs_ack, 64'd1);
    run_chunk(OFS0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chunk_row_looper.md
# chunk_row_looper

Parametrised row-start generator for the ChunkAddrLooper stage of the TileAccumUnit read pipeline. It accepts one chunk descriptor per handshake and walks an N-dimensional outer-row counter. For each row it emits the linear global start address, a pad amount, a last-row flag and an out-of-bounds flag. Unlike the previous generation, it latches the descriptor so the next chunk can queue. It also provides per-dimension clamp/wrap/zero boundary modes and sustains one registered row per cycle.

## Interface
- GBW, 32, global address width; all address and offset fields are GBW bits, two's complement.
- DIM, 4, tile dimension count; the counter spans dims 0..DIM-2, with dim DIM-2 innermost.
- V_BW, 3, pad field width.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_mofs_rdy  in  1  descriptor valid.
- o_mofs_ack  out  1  descriptor accepted.
- i_mofs  in  GBW×(DIM-1)  signed per-dim offset, pre-scaled to linear units.
- i_mstride  in  GBW×(DIM-1)  per-dim counter step, >0.
- i_mlast  in  GBW×(DIM-1)  inclusive counter end, a multiple of the step.
- i_mbound  in  GBW×(DIM-1)  largest legal position, ≥0.
- i_mmode  in  2×(DIM-1)  boundary mode: 0 clamp, 1 wrap, 2 zero, 3 reserved (treated as clamp).
- i_mpad  in  V_BW×DIM  pad table.
- i_maddr  in  GBW  chunk base address.
- o_row_rdy  out  1  row valid.
- i_row_ack  in  1  row accepted.
- o_row_linear  out  GBW  row start address.
- o_row_pad  out  V_BW  pad for this row.
- o_row_islast  out  1  final row of the chunk.
- o_row_oob  out  1  row lies outside a zero-mode dim; downstream fills the row with zeros.

## Operation
- FSM states are IDLE and RUN.
- o_mofs_ack = IDLE (combinational). A transfer occurs when rdy && ack.
  - On transfer, all i_m* fields are latched into configuration registers, cur[] is cleared to 0, and the FSM goes to RUN.
  - Inputs are don't-care after the transfer.
- In RUN, a row is generated whenever the output register is empty or is being acked this cycle. Each generated row:
  - loads the output register;
  - advances the counter.
- Counter advance:
  - The innermost dim j with cur[j]≠mlast[j] adds mstride[j].
  - All deeper dims reset to 0.
  - Last row: every cur[i]==mlast[i]. The row is loaded with islast=1 and the FSM returns to IDLE.
- Row address, per dim i: u=cur[i]+mofs[i], compared signed against 0 and mbound[i].
  - clamp: u<0 gives 0; u>mbound gives mbound; otherwise u.
  - wrap: u<0 gives u+mbound+mstride; u>mbound gives u−mbound−mstride; one correction only, so |mofs|≤mbound+mstride is required.
  - zero: maps as clamp, and the out-of-range condition sets oob.
  - o_row_linear = maddr + Σ mapped(i), modulo 2^GBW.
- Pad: islast selects i_mpad[0]; otherwise i_mpad[j+1], where j is the dim that increments after this row.
- Output register fields hold stable while o_row_rdy && !i_row_ack.

## Timing
- Reset values:
  - FSM = IDLE, cur[] = 0, o_row_rdy = 0;
  - o_row_linear/pad/islast/oob = 0;
  - o_mofs_ack = 1 (IDLE).
- Latency: descriptor accepted at cycle t gives first o_row_rdy at t+1. Throughput is one row per cycle under continuous ack.
- Back-to-back chunks: if the last row is loaded at cycle k, IDLE holds at k+1, the next descriptor is acked at k+1, and its first row appears at k+2. This one-bubble gap between chunks is the required behaviour.
- The last row may still be pending in the output register while the next descriptor is accepted. The register updates only on ack.
- o_row_rdy must not depend combinationally on i_row_ack. o_mofs_ack depends only on state.
- Reset asserted mid-RUN: all state and outputs go to reset values immediately. A pending row is discarded.
- Single-row chunk (all mlast=0): islast=1 on the first row.

## Test plan
- Clamp walk: DIM=3, maddr=1000, stride=[4,1], mlast=[8,2], bound=[8,3], ofs=[0,0], mode clamp, ack always.
  - Required: 9 rows 1000,1001,1002,1004,1005,1006,1008,1009,1010, one per cycle, with islast only on 1010.
- Clamp low: same setup with ofs=[-4,0].
  - Required: 1000,1001,1002,1000,1001,1002,1004,1005,1006.
- Wrap: dim0 in wrap mode, ofs=[-4,0].
  - Required: first three rows 1008,1009,1010; then 1000–1002; then 1004–1006.
- Zero: dim0 in zero mode, ofs=[-4,0].
  - Required: oob=1 on rows 1–3 only, with addresses as in the clamp-low case.
- Backpressure and queuing: hold i_row_ack=0 for 3 cycles mid-chunk while a second descriptor is asserted.
  - Required: outputs remain stable, no rows are lost, the second descriptor is acked on the cycle after the last row loads, and its first row appears 2 cycles after that load.
- Reset mid-RUN: drop i_rst after 4 rows.
  - Required: o_row_rdy=0 and all outputs 0 asynchronously. After release, o_mofs_ack=1, and a fresh descriptor restarts the walk from cur=0.
